adc_capture_sequencer: RTL

- Sequences one serial ADC capture run: ADC chip-select and SPI clock generation, serial-to-parallel shifting, and buffer-RAM write commands.
- A `start` pulse triggers a burst of NUM_SAMPLES conversions at a fixed sample rate.
- Each 10-bit sample is written to incrementing RAM addresses; `done` is flagged at the end.
- Replaces the free-running chip-select/SIPO pairing with a single-clock sequencer feeding the sample RAM and the display path.

---
 rtl/adc_capture_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: one serial ADC capture run (CS/SCLK generation, SIPO shift, RAM write strobes).
// Define ADC_CAPTURE_RING_EN for continuous ring capture; default build is single-shot.
module adc_capture_sequencer #(
  parameter int DATA_W        = 10,
  parameter int FRAME_BITS    = 16,
  parameter int LEAD_BITS     = 4,
  parameter int SCLK_DIV      = 7,
  parameter int SAMPLE_PERIOD = 400,
  parameter int ADDR_W        = 10,
  parameter int NUM_SAMPLES   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              adc_sdata,
  output logic              adc_cs,
  output logic              adc_sclk,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count
);
  localparam int CW = ADDR_W + 1;
  localparam int PW = $clog2(SAMPLE_PERIOD + SCLK_DIV * (2 * FRAME_BITS + 1) + 4);
  localparam int DW = $clog2(SCLK_DIV + 1);
  localparam int TW = $clog2(2 * FRAME_BITS + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  typedef enum logic [2:0] {IDLE, WAIT, FRAME, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DATA_W-1:0] sh, sh_n, wr_data_n;
  logic [ADDR_W-1:0] addr, addr_n, wr_addr_n;
  logic [ADDR_W:0] count_n;
  logic cs_n, sclk_n, wr_en_n, busy_n, done_n;
  always_comb begin
    state_n = state;
    pcnt_n = pcnt + 1'b1;
    dcnt_n = dcnt;
    tcnt_n = tcnt;
    bcnt_n = bcnt;
    sh_n = sh;
    addr_n = addr;
    count_n = sample_count;
    cs_n = 1'b1;
    sclk_n = 1'b1;
    wr_en_n = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    busy_n = busy;
`ifdef ADC_CAPTURE_RING_EN
    done_n = 1'b0;
`else
    done_n = done;
`endif
    case (state)
      IDLE, DONE: if (start) begin
        state_n = FRAME;
        pcnt_n = '0;
        dcnt_n = '0;
        tcnt_n = '0;
        bcnt_n = '0;
        count_n = '0;
        addr_n = '0;
        done_n = 1'b0;
        busy_n = 1'b1;
        cs_n = 1'b0;
      end
      // >= so an overrunning frame restarts on the very next cycle
      WAIT: if (pcnt >= PW'(SAMPLE_PERIOD - 1)) begin
        state_n = FRAME;
        pcnt_n = '0;
        dcnt_n = '0;
        tcnt_n = '0;
        bcnt_n = '0;
        cs_n = 1'b0;
      end
      FRAME: begin
        cs_n = 1'b0;
        sclk_n = adc_sclk;
        dcnt_n = dcnt + 1'b1;
        if (dcnt == DW'(SCLK_DIV - 1)) begin
          dcnt_n = '0;
          if (tcnt == TW'(2 * FRAME_BITS)) begin
            state_n = WRITE;
            cs_n = 1'b1;
            wr_en_n = 1'b1;
            wr_addr_n = addr;
            wr_data_n = sh;
          end else begin
            sclk_n = ~adc_sclk;
            tcnt_n = tcnt + 1'b1;
            // sclk low now means this edge drives it high: sample here
            if (!adc_sclk) begin
              bcnt_n = bcnt + 1'b1;
              if (bcnt >= BW'(LEAD_BITS) && bcnt < BW'(LEAD_BITS + DATA_W))
                sh_n = {sh[DATA_W-2:0], adc_sdata};
            end
          end
        end
      end
      WRITE: begin
        state_n = WAIT;
`ifdef ADC_CAPTURE_RING_EN
        addr_n = (addr == ADDR_W'(NUM_SAMPLES - 1)) ? '0 : addr + 1'b1;
        count_n = (sample_count == CW'(NUM_SAMPLES)) ? sample_count : sample_count + 1'b1;
        done_n = (addr == ADDR_W'(NUM_SAMPLES - 1));
`else
        addr_n = addr + 1'b1;
        count_n = sample_count + 1'b1;
        if (count_n == CW'(NUM_SAMPLES)) begin
          state_n = DONE;
          busy_n = 1'b0;
          done_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    if (abort && state inside {WAIT, FRAME, WRITE}) begin
      state_n = IDLE;
      cs_n = 1'b1;
      sclk_n = 1'b1;
      wr_en_n = 1'b0;
      busy_n = 1'b0;
      done_n = 1'b0;
      count_n = sample_count;
      addr_n = addr;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pcnt <= '0;
      dcnt <= '0;
      tcnt <= '0;
      bcnt <= '0;
      sh <= '0;
      addr <= '0;
      sample_count <= '0;
      adc_cs <= 1'b1;
      adc_sclk <= 1'b1;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      pcnt <= pcnt_n;
      dcnt <= dcnt_n;
      tcnt <= tcnt_n;
      bcnt <= bcnt_n;
      sh <= sh_n;
      addr <= addr_n;
      sample_count <= count_n;
      adc_cs <= cs_n;
      adc_sclk <= sclk_n;
      wr_en <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule
